// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the reversible-counter run-control sequencer.
// State encoding and direction-input meanings.
package counter_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_RUN   = 3'd2,
      ST_PAUSE = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   localparam logic DIR_UP   = 1'b0;
   localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/rev_counter_ctrl_btn_edge.sv
// Rising-edge detector for a debounced push-button level.
// The edge pulse is registered, so it is seen one cycle after the button rises.
module btn_edge (
   input  logic clk,
   input  logic rst,
   input  logic btn,
   output logic rise
);

   logic hist_reg;
   logic rise_reg;

   always_ff @(posedge clk) begin
      if (!rst) begin
         hist_reg <= 1'b0;
         rise_reg <= 1'b0;
      end else begin
         hist_reg <= btn;
         rise_reg <= btn & ~hist_reg;
      end
   end

   assign rise = rise_reg;

endmodule

// File: rtl/rev_counter_ctrl.sv
// Run-control sequencer for the reversible counter: step/load strobes,
// terminal-count stop or wrap, done LED and blinking display blank mask.
module rev_counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH       = 16,
   parameter int TICK_DIV    = 1,
   parameter int BLINK_TICKS = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick,
   input  logic             btn_start,
   input  logic             btn_clear,
   input  logic             dir,
   input  logic             wrap,
   input  logic [WIDTH-1:0] preset,
   input  logic [WIDTH-1:0] cnt_q,
   output logic             cnt_ce,
   output logic             cnt_up,
   output logic             cnt_ld,
   output logic [WIDTH-1:0] cnt_din,
   output logic             done,
   output logic [3:0]       les
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_TICKS - 1);

   // Index 0 = start, index 1 = clear.
   logic [1:0] btn_lvl;
   logic [1:0] btn_rise;
   logic       start_rise;
   logic       clear_rise;

   assign btn_lvl = {btn_clear, btn_start};

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         btn_edge u_btn_edge (
            .clk  (clk),
            .rst  (rst),
            .btn  (btn_lvl[gi]),
            .rise (btn_rise[gi])
         );
      end
   endgenerate

   assign start_rise = btn_rise[0];
   assign clear_rise = btn_rise[1];

   state_t           state_reg, state_next;
   logic             cnt_ce_reg, cnt_ce_next;
   logic             cnt_ld_reg, cnt_ld_next;
   logic             cnt_up_reg, cnt_up_next;
   logic [WIDTH-1:0] cnt_din_reg, cnt_din_next;
   logic             done_reg, done_next;
   logic [3:0]       les_reg, les_next;
   logic [PW-1:0]    presc_reg, presc_next;
   logic [BW-1:0]    blink_cnt_reg, blink_cnt_next;
   logic             blink_reg, blink_next;
   logic [WIDTH-1:0] clear_val;
   logic [WIDTH-1:0] terminal;
   logic             blink_state;

   assign clear_val = (dir == DIR_DOWN) ? preset : '0;
   assign terminal  = cnt_up_reg ? preset : '0;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg     <= ST_INIT;
         cnt_ce_reg    <= 1'b0;
         cnt_ld_reg    <= 1'b0;
         cnt_up_reg    <= 1'b1;
         cnt_din_reg   <= '0;
         done_reg      <= 1'b0;
         les_reg       <= 4'b0000;
         presc_reg     <= '0;
         blink_cnt_reg <= '0;
         blink_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_ce_reg    <= cnt_ce_next;
         cnt_ld_reg    <= cnt_ld_next;
         cnt_up_reg    <= cnt_up_next;
         cnt_din_reg   <= cnt_din_next;
         done_reg      <= done_next;
         les_reg       <= les_next;
         presc_reg     <= presc_next;
         blink_cnt_reg <= blink_cnt_next;
         blink_reg     <= blink_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_ce_next    = 1'b0;
      cnt_ld_next    = 1'b0;
      cnt_up_next    = cnt_up_reg;
      cnt_din_next   = cnt_din_reg;
      presc_next     = presc_reg;
      blink_cnt_next = '0;
      blink_next     = 1'b0;
      blink_state    = 1'b0;

      if (state_reg == ST_INIT) begin
         cnt_ld_next  = 1'b1;
         cnt_din_next = clear_val;
         state_next   = ST_IDLE;
      end else if (clear_rise) begin
         // Clear outranks start and any step due this cycle.
         cnt_ld_next  = 1'b1;
         cnt_din_next = clear_val;
         presc_next   = '0;
         state_next   = ST_IDLE;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               cnt_up_next = (dir == DIR_UP);
               if (start_rise) begin
                  presc_next = '0;
                  state_next = ST_RUN;
               end
            end
            ST_RUN: begin
               if (start_rise) begin
                  state_next = ST_PAUSE;
               end else if (tick) begin
                  if (presc_reg == PRESC_LAST) begin
                     presc_next = '0;
                     // Wrapping relies on natural counter overflow, not on preset.
                     if ((cnt_q != terminal) || wrap) begin
                        cnt_ce_next = 1'b1;
                     end else begin
                        state_next = ST_DONE;
                     end
                  end else begin
                     presc_next = presc_reg + PW'(1);
                  end
               end
            end
            ST_PAUSE: begin
               cnt_up_next = (dir == DIR_UP);
               if (start_rise) begin
                  state_next = ST_RUN;
               end
            end
            ST_DONE: begin
               if (start_rise) begin
                  cnt_ld_next  = 1'b1;
                  cnt_din_next = clear_val;
                  state_next   = ST_IDLE;
               end
            end
            default: begin
               state_next = ST_INIT;
            end
         endcase
      end

      // Blink only runs while staying in PAUSE or DONE; any entry restarts unblanked.
      blink_state = (state_next == ST_PAUSE) || (state_next == ST_DONE);
      if (blink_state && (state_next == state_reg)) begin
         blink_cnt_next = blink_cnt_reg;
         blink_next     = blink_reg;
         if (tick) begin
            if (blink_cnt_reg == BLINK_LAST) begin
               blink_cnt_next = '0;
               blink_next     = ~blink_reg;
            end else begin
               blink_cnt_next = blink_cnt_reg + BW'(1);
            end
         end
      end

      les_next  = {4{blink_next}};
      done_next = (state_next == ST_DONE);
   end

   assign cnt_ce  = cnt_ce_reg;
   assign cnt_ld  = cnt_ld_reg;
   assign cnt_up  = cnt_up_reg;
   assign cnt_din = cnt_din_reg;
   assign done    = done_reg;
   assign les     = les_reg;

endmodule

// File: tb/tb_rev_counter_ctrl.sv
// Directed, table-driven bench for rev_counter_ctrl with behavioural counters
// closing the cnt_q loop; a second instance covers TICK_DIV = 3.
module tb_rev_counter_ctrl;

   logic        clk;
   logic        rst;
   logic        tick;
   logic        btn_start;
   logic        btn_clear;
   logic        dir;
   logic        wrap;
   logic [15:0] preset;

   logic [15:0] cnt_q1, cnt_q3;
   logic        ce1, up1, ld1, done1;
   logic        ce3, up3, ld3, done3;
   logic [15:0] din1, din3;
   logic [3:0]  les1, les3;

   int checks = 0;
   int errors = 0;
   logic mon_en = 1'b0;

   rev_counter_ctrl #(.WIDTH(16), .TICK_DIV(1), .BLINK_TICKS(5)) dut (
      .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
      .dir(dir), .wrap(wrap), .preset(preset), .cnt_q(cnt_q1),
      .cnt_ce(ce1), .cnt_up(up1), .cnt_ld(ld1), .cnt_din(din1), .done(done1), .les(les1)
   );

   rev_counter_ctrl #(.WIDTH(16), .TICK_DIV(3), .BLINK_TICKS(5)) dut3 (
      .clk(clk), .rst(rst), .tick(tick), .btn_start(btn_start), .btn_clear(btn_clear),
      .dir(dir), .wrap(wrap), .preset(preset), .cnt_q(cnt_q3),
      .cnt_ce(ce3), .cnt_up(up3), .cnt_ld(ld3), .cnt_din(din3), .done(done3), .les(les3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-ins for the counter datapath.
   initial begin
      cnt_q1 = 16'h5A5A;
      cnt_q3 = 16'h5A5A;
   end
   always @(posedge clk) begin
      if (ld1)      cnt_q1 <= din1;
      else if (ce1) cnt_q1 <= up1 ? cnt_q1 + 16'd1 : cnt_q1 - 16'd1;
      if (ld3)      cnt_q3 <= din3;
      else if (ce3) cnt_q3 <= up3 ? cnt_q3 + 16'd1 : cnt_q3 - 16'd1;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if ((ce1 && ld1) || (ce3 && ld3)) begin
            errors++;
            $display("FAIL ce_ld_exclusive: got ce1=%b ld1=%b ce3=%b ld3=%b, required not both high", ce1, ld1, ce3, ld3);
         end
      end
   end

   typedef struct {
      logic        tick;
      logic        start;
      logic        clear;
      logic        dir;
      logic        wrap;
      logic [15:0] preset;
      logic        ce;
      logic        ld;
      logic        up;
      logic        done;
      logic [3:0]  les;
      logic [15:0] din;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic t, input logic st, input logic cl, input logic d,
                      input logic w, input logic [15:0] p, input logic ce, input logic ld,
                      input logic up, input logic dn, input logic [3:0] ls, input logic [15:0] dv);
      vec_t v;
      v.tick = t; v.start = st; v.clear = cl; v.dir = d; v.wrap = w; v.preset = p;
      v.ce = ce; v.ld = ld; v.up = up; v.done = dn; v.les = ls; v.din = dv;
      vecs.push_back(v);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h", name, got, exp);
      end else begin
         $display("ok   %s: %h", name, got);
      end
   endtask

   initial begin
      tick = 0; btn_start = 0; btn_clear = 0;
      dir = 0; wrap = 0; preset = 16'h0003; rst = 0;

      // Reset, then INIT issues one load of the up-mode clear value.
      cycle(); cycle();
      check("reset_state", {8'h0, ce1, ld1, up1, done1, les1, din1}, {8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0000});
      rst = 1;
      cycle();
      check("init_load", {8'h0, ce1, ld1, up1, done1, les1, din1}, {8'h0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h0, 16'h0000});
      mon_en = 1'b1;
      cycle();
      check("idle_after_init", {28'h0, ce1, ld1, up1, done1}, {28'h0, 4'b0010});

      // Up mode, preset 3, stop at terminal: 3 steps, 4th tick sets done.
      add(0,1,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);   // 0
      add(0,1,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);
      add(1,0,0,0,0,16'h3, 1,0,1,0,4'h0,16'h0);   // tick 1, q=0
      add(0,0,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);
      add(0,0,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);
      add(1,0,0,0,0,16'h3, 1,0,1,0,4'h0,16'h0);   // 5: tick 2, q=1
      add(0,0,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);
      add(0,0,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);
      add(1,0,0,0,0,16'h3, 1,0,1,0,4'h0,16'h0);   // tick 3, q=2
      add(0,0,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);
      add(0,0,0,0,0,16'h3, 0,0,1,0,4'h0,16'h0);   // 10
      add(1,0,0,0,0,16'h3, 0,0,1,1,4'h0,16'h0);   // tick 4, q=3 terminal
      add(0,0,0,0,0,16'h3, 0,0,1,1,4'h0,16'h0);
      add(0,0,0,0,0,16'h3, 0,0,1,1,4'h0,16'h0);
      add(1,0,0,0,0,16'h3, 0,0,1,1,4'h0,16'h0);   // tick 5 ignored in DONE
      // Start in DONE reloads (down mode now -> preset), then down run with wrap.
      add(0,1,0,1,1,16'h2, 0,0,1,1,4'h0,16'h0);   // 15
      add(0,1,0,1,1,16'h2, 0,1,1,0,4'h0,16'h2);
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(0,1,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(0,1,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(1,0,0,1,1,16'h2, 1,0,0,0,4'h0,16'h0);   // 20: q=2
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(1,0,0,1,1,16'h2, 1,0,0,0,4'h0,16'h0);   // q=1
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);   // 25
      add(1,0,0,1,1,16'h2, 1,0,0,0,4'h0,16'h0);   // q=0 terminal, wraps
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(1,0,0,1,1,16'h2, 1,0,0,0,4'h0,16'h0);   // q=FFFF
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);   // 30
      // Pause, 10 ticks of blinking, then resume.
      add(0,1,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      add(0,1,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);   // now PAUSE
      for (int k = 1; k <= 10; k++) begin
         add(1,0,0,1,1,16'h2, 0,0,0,0,(k >= 5 && k < 10) ? 4'hF : 4'h0,16'h0);
         if (k < 10) begin
            add(0,0,0,1,1,16'h2, 0,0,0,0,(k >= 5) ? 4'hF : 4'h0,16'h0);
            add(0,0,0,1,1,16'h2, 0,0,0,0,(k >= 5) ? 4'hF : 4'h0,16'h0);
         end
      end
      add(0,1,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);   // 61
      add(0,1,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);   // back to RUN
      add(1,0,0,1,1,16'h2, 1,0,0,0,4'h0,16'h0);   // q=FFFE
      add(0,0,0,1,1,16'h2, 0,0,0,0,4'h0,16'h0);
      // Clear and start together, with a tick on the acting cycle.
      add(0,1,1,1,1,16'h10, 0,0,0,0,4'h0,16'h0);  // 65
      add(1,1,1,1,1,16'h10, 0,1,0,0,4'h0,16'h10);
      add(0,0,0,1,1,16'h10, 0,0,0,0,4'h0,16'h0);
      add(0,0,0,1,1,16'h10, 0,0,0,0,4'h0,16'h0);
      add(1,0,0,1,1,16'h10, 0,0,0,0,4'h0,16'h0);  // IDLE: no step
      add(0,0,0,1,1,16'h10, 0,0,0,0,4'h0,16'h0);  // 70

      for (int i = 0; i < vecs.size(); i++) begin
         tick = vecs[i].tick; btn_start = vecs[i].start; btn_clear = vecs[i].clear;
         dir = vecs[i].dir; wrap = vecs[i].wrap; preset = vecs[i].preset;
         cycle();
         check($sformatf("vec%0d ce/ld/up/done/les", i),
               {24'h0, ce1, ld1, up1, done1, les1},
               {24'h0, vecs[i].ce, vecs[i].ld, vecs[i].up, vecs[i].done, vecs[i].les});
         if (vecs[i].ld) check($sformatf("vec%0d din", i), {16'h0, din1}, {16'h0, vecs[i].din});
         if (i == 14) check("cnt_q_after_up_run", {16'h0, cnt_q1}, 32'h0003);
         if (i == 30) check("cnt_q_after_down_wrap", {16'h0, cnt_q1}, 32'hFFFE);
         if (i == 70) check("cnt_q_after_clear", {16'h0, cnt_q1}, 32'h0010);
      end
      tick = 0; btn_start = 0; btn_clear = 0;

      // TICK_DIV = 3 instance: reset, start, 9 ticks with reset on the 7th.
      mon_en = 1'b0;
      rst = 0; dir = 0; wrap = 0; preset = 16'h0100;
      cycle();
      check("td3_reset_state", {8'h0, ce3, ld3, up3, done3, les3, din3}, {8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0000});
      rst = 1;
      cycle();
      check("td3_init_load", {30'h0, ce3, ld3}, 32'h1);
      mon_en = 1'b1;
      cycle();
      btn_start = 1; cycle(); cycle();
      btn_start = 0;
      for (int k = 1; k <= 9; k++) begin
         tick = 1;
         if (k == 7) rst = 0;
         cycle();
         tick = 0;
         if (k == 7) begin
            check("td3_reset_mid_run", {8'h0, ce3, ld3, up3, done3, les3, din3}, {8'h0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 16'h0000});
            rst = 1;
         end else begin
            check($sformatf("td3_tick%0d ce", k), {31'h0, ce3}, {31'h0, (k == 3 || k == 6)});
         end
         cycle();
         check($sformatf("td3_tick%0d ce_after", k), {31'h0, ce3}, 32'h0);
         cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
